// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared types and constants for the systolic array feeder
package sys_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_t;

    localparam int FEEDER_LEN_W = 16;
    localparam int STALL_CNT_W  = 16;

endpackage

// File: rtl/sys_array_skew_line.sv
// rtl/sys_array_skew_line.sv - DEPTH-stage data+valid delay line for one array row
module sys_array_skew_line #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            data_q[0]  <= in_data;
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// rtl/sys_array_feeder.sv - diagonal skew feeder for the systolic array; SYS_FEEDER_STALL_CNT_EN adds a stall counter
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_H    = 4,
    parameter int LEN_W      = FEEDER_LEN_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [LEN_W-1:0]              len,
    output logic                          busy,
    output logic                          done,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ARRAY_H*DATA_WIDTH-1:0] in_data,
    output logic [ARRAY_H*DATA_WIDTH-1:0] out_data,
    output logic [ARRAY_H-1:0]            out_valid,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    localparam int DCW = (ARRAY_H > 2) ? $clog2(ARRAY_H) : 1;

    feeder_state_t    state;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_q;
    logic [DCW-1:0]   drain_cnt;
    logic             accept;

    assign accept = in_valid & in_ready;

    // busy/done/in_ready are registered alongside the state they decode
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            len_q     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        beat_cnt <= '0;
                        len_q    <= len;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            state    <= ST_STREAM;
                            in_ready <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == len_q - 1'b1) begin
                            in_ready <= 1'b0;
                            if (ARRAY_H == 1) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= ST_DRAIN;
                                drain_cnt <= DCW'(ARRAY_H - 2);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bubbles enter as zero so the array never sees stale operands
    for (genvar r = 0; r < ARRAY_H; r++) begin : g_row
        sys_array_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (r + 1)
        ) u_line (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_data   (accept ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : {DATA_WIDTH{1'b0}}),
            .in_valid  (accept),
            .out_data  (out_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (out_valid[r])
        );
    end

`ifdef SYS_FEEDER_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (state == ST_IDLE && start) begin
            stall_q <= '0;
        end else if (state == ST_STREAM && !in_valid && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// tb/tb_sys_array_feeder.sv - directed self-checking bench for sys_array_feeder
module tb_sys_array_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [15:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int done_at;
    logic [31:0] vecs [8];
    logic [15:0] exp_stall;

    sys_array_feeder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
    endtask

    // Drives one job already in STREAM; checks every row, done, busy and in_ready per cycle
    task automatic run_job(input string tag, input int ncyc, input logic [15:0] vpat,
                           input int nbeats, input int busy_start_k, output int d_at);
        int acc_k [8];
        int sent = 0;
        int last = 0;
        logic [7:0] ed;
        logic       ev;
        logic       ed_done;
        d_at = -1;
        for (int k = 0; k < ncyc; k++) begin
            in_valid = vpat[k];
            in_data  = (vpat[k] && sent < nbeats) ? vecs[sent] : 32'hdeadbeef;
            start    = (k == busy_start_k);
            len      = 16'd9;
            for (int r = 0; r < 4; r++) begin
                ed = 8'h00;
                ev = 1'b0;
                for (int j = 0; j < sent; j++)
                    if (acc_k[j] + 1 + r == k) begin
                        ed = vecs[j][r*8 +: 8];
                        ev = 1'b1;
                    end
                check($sformatf("%s_data_r%0d_k%0d", tag, r, k), out_data[r*8 +: 8], ed);
                check($sformatf("%s_valid_r%0d_k%0d", tag, r, k), out_valid[r], ev);
            end
            ed_done = (sent == nbeats) && (k == last + 4);
            check($sformatf("%s_done_k%0d", tag, k), done, ed_done);
            check($sformatf("%s_ready_k%0d", tag, k), in_ready, sent < nbeats);
            check($sformatf("%s_busy_k%0d", tag, k), busy, !((sent == nbeats) && (k > last + 4)));
            if (done) d_at = k;
            if (vpat[k] && sent < nbeats) begin
                acc_k[sent] = k;
                last = k;
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'($urandom);
        len      = 16'($urandom);
        in_valid = 1'($urandom);
        in_data  = $urandom;
        step();
        start    = 1'($urandom);
        in_valid = 1'($urandom);
        in_data  = $urandom;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        len      = '0;
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_stall", stall_cnt, 16'h0);
        reset_n = 1'b1;
        step();

        // back-to-back: row 2 shows 3,7,11 at t+3..t+5, done at t+6
        vecs[0] = 32'h04030201;
        vecs[1] = 32'h08070605;
        vecs[2] = 32'h0c0b0a09;
        start_job(16'd3);
        run_job("b2b", 10, 16'b0111, 3, -1, done_at);
        check("b2b_done_cycle", done_at, 32'd6);
        check("b2b_stall", stall_cnt, 16'd0);

        // two-cycle bubble between beats
        vecs[0] = 32'h44332211;
        vecs[1] = 32'h88776655;
        start_job(16'd2);
        run_job("bub", 10, 16'b1001, 2, -1, done_at);
        check("bub_done_cycle", done_at, 32'd7);
`ifdef SYS_FEEDER_STALL_CNT_EN
        exp_stall = 16'd2;
`else
        exp_stall = 16'd0;
`endif
        check("bub_stall", stall_cnt, exp_stall);

        // len = 0
        start = 1'b1;
        len   = 16'd0;
        check("len0_ready_pre", in_ready, 1'b0);
        step();
        start = 1'b0;
        check("len0_done", done, 1'b1);
        check("len0_ready", in_ready, 1'b0);
        check("len0_valid", out_valid, 4'h0);
        step();
        check("len0_done_drop", done, 1'b0);
        check("len0_busy_drop", busy, 1'b0);
        check("len0_ready2", in_ready, 1'b0);

        // start with len=9 while streaming must not change the job
        vecs[0] = 32'hcafef00d;
        vecs[1] = 32'h01020304;
        start_job(16'd2);
        run_job("busy", 10, 16'b0110, 2, 0, done_at);
        check("busy_done_cycle", done_at, 32'd6);

        // signed extremes pass bit-exact
        vecs[0] = 32'h7f807f80;
        start_job(16'd1);
        run_job("sgn", 7, 16'b0001, 1, -1, done_at);
        check("sgn_done_cycle", done_at, 32'd4);

        // reset in DRAIN
        start_job(16'd1);
        in_valid = 1'b1;
        in_data  = 32'h11223344;
        step();
        in_valid = 1'b0;
        check("mid_row0_valid", out_valid, 4'b0001);
        check("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_valid", out_valid, 4'h0);
        check("mid_rst_data", out_data, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_stall", stall_cnt, 16'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("mid_after_done_k%0d", k), done, 1'b0);
            check($sformatf("mid_after_valid_k%0d", k), out_valid, 4'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sys_array_feeder.md
# sys_array_feeder

Input skew feeder for the systolic array. Accepts one column vector of ARRAY_H signed operands per beat over a valid/ready handshake. Presents element r to array row r delayed by r cycles, forming the diagonal wavefront the cells need. Runs a job of `len` vectors and flushes the skew before signalling completion; a per-row valid bit travels with the data so the downstream collector can discard bubbles.

## Interface
- DATA_WIDTH, 8: operand width; matches the array cells.
- ARRAY_H, 4: number of array rows (vector elements), ≥1.
- LEN_W, 16: width of the job length field.

- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  job start; honoured only in IDLE.
- len  in  LEN_W  number of vectors in the job; sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in DONE.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  high exactly when state is STREAM.
- in_data  in  ARRAY_H*DATA_WIDTH  signed elements; element r is [r*DATA_WIDTH +: DATA_WIDTH].
- out_data  out  ARRAY_H*DATA_WIDTH  skewed row operands to the array `input_data` ports.
- out_valid  out  ARRAY_H  per-row valid, skewed identically to the data.
- stall_cnt  out  16  count of STREAM cycles with in_valid low (see Configuration).

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE→STREAM on start with len≠0.
  - IDLE→DONE on start with len=0.
  - STREAM→DRAIN on the accept of beat `len`. Goes directly to DONE if ARRAY_H=1.
  - DRAIN→DONE after ARRAY_H−1 cycles.
  - DONE→IDLE unconditionally.
- Accept = in_valid & in_ready. The beat counter increments per accept and clears on start.
- start while busy is ignored; len is not resampled.
- Row r skew line, depth r+1 registers:
  - On an accept, element r enters with valid=1.
  - Every other cycle, 0 enters with valid=0.
  - Lines shift every cycle in all states, never stall.
- Data passes through unmodified; no arithmetic. Sign is preserved; −128 at 8 bits stays 0x80.
- Reset, at any time including mid-job:
  - state returns to IDLE; beat counter, out_data, out_valid, done, busy, in_ready and stall_cnt all become 0.
  - Partially fed jobs are abandoned.

## Timing
- Accept in cycle t → element r visible on out_data/out_valid row r in cycle t+1+r.
- Last accept in cycle t → done high in cycle t+ARRAY_H, the same cycle as the last out_valid[ARRAY_H−1].
- len=0: done in the cycle after start; in_ready never rises.
- in_ready is a registered-state decode.
  - It is high in the first STREAM cycle, the cycle after start.
  - It drops in the cycle after the final accept.
- Outputs are registered; there is no combinational path from in_data or in_valid to any output.

## Configuration
- SYS_FEEDER_STALL_CNT_EN:
  - Defined: stall_cnt clears on start and increments each STREAM cycle with in_valid low. It saturates at 16'hFFFF and holds its value through DONE and IDLE until the next start.
  - Undefined: stall_cnt is tied to 0 and no counter logic is built.

## Structure
- Shared package sys_array_pkg holds:
  - the feeder state enum (IDLE, STREAM, DRAIN, DONE);
  - the default LEN_W;
  - the stall counter width constant (16).
- Sub-module sys_array_skew_line:
  - parameters DATA_WIDTH and DEPTH;
  - carries data plus valid through DEPTH registers, cleared by reset_n;
  - the feeder instantiates it per row with DEPTH=r+1 in a generate loop.

## Test plan
- Reset: hold reset_n low 2 cycles with random inputs → all outputs 0, busy=0, in_ready=0.
- Back-to-back job, ARRAY_H=4:
  - Stimulus: start, len=3; vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} with continuous in_valid; first accept in cycle t.
  - Row 2 shows 3, 7, 11 in cycles t+3..t+5.
  - done in cycle t+6 only; stall_cnt=0.
- Bubbles:
  - Stimulus: len=2; in_valid low 2 cycles between the beats.
  - Each row shows beat, two valid=0 zeros, beat, skewed per row.
  - stall_cnt=2 with macro, 0 without.
- len=0: start → done in the next cycle; in_ready stays 0; no out_valid bits rise.
- Start while busy and reset mid-stream:
  - A second start during STREAM with len=9 leaves the job length unchanged.
  - reset_n low in DRAIN → the next cycle shows IDLE and all-zero out_valid/out_data.
- Signed extremes: element values −128 and 127 → identical bit patterns appear on the skewed outputs.
